passive_security_ctrl: RTL and testbench
========================================

// Module: passive_security_ctrl
// PURPOSE
// - Passive anti-theft controller: the device under test that the passive-security tester stimulates.
// - Consumes the car status lines CarLightsOnSign, OpenDoorSign and IgnitionSignalOn.
// - Produces PassiveSignal_s (security armed) and PassiveSignal_b (lights-left-on buzzer).
// - Sits between the tester and the data monitor, in both its behavioural and structural forms.
// - Arms automatically: ignition off, driver door opened then closed, door held closed ARM_DELAY cycles.
// PARAMETERS
// - ARM_DELAY  default 10 : clk edges, door closed, from COUNTDOWN entry to ARMED (>=1)
// - BUZZ_MAX   default 8  : max consecutive cycles PassiveSignal_b stays high per warning event (>=1)
// - CNT_W      default 8  : counter width; requires ARM_DELAY, BUZZ_MAX <= 2**CNT_W-1
// PORTS
// - clk               in   1  system clock, all state updates on posedge
// - reset             in   1  asynchronous, active-high; clears all state and outputs immediately
// - CarLightsOnSign   in   1  1 = headlights on
// - OpenDoorSign      in   1  1 = driver door open
// - IgnitionSignalOn  in   1  1 = ignition on
// - PassiveSignal_b   out  1  registered buzzer, lights-on warning
// - PassiveSignal_s   out  1  registered security-armed indicator
// BEHAVIOUR
// - Reset (async): state=IDLE, arm_cnt=0, buzz_cnt=0, PassiveSignal_s=0, PassiveSignal_b=0.
//   - Effect is immediate, not at the next edge.
//   - Reset mid-countdown aborts arming; a fresh open/close sequence is required.
// - Arming FSM, evaluated on posedge clk; IgnitionSignalOn=1 has top priority in every state:
//   go to IDLE and clear arm_cnt.
//   - IDLE: ign=0 -> WAIT_OPEN.
//   - WAIT_OPEN: door=1 -> WAIT_CLOSE; else stay.
//   - WAIT_CLOSE: door=0 -> COUNTDOWN with arm_cnt=0; else stay.
//   - COUNTDOWN, door=1: -> WAIT_CLOSE, arm_cnt=0 (countdown restarts on next close).
//   - COUNTDOWN, door=0 and arm_cnt==ARM_DELAY-1: -> ARMED.
//   - COUNTDOWN, door=0 otherwise: arm_cnt+1.
//   - ARMED: stay until ign=1; door activity ignored.
// - Arming latency: door=0 sampled at edge E0 (entering COUNTDOWN) -> ARMED at edge E0+ARM_DELAY.
// - PassiveSignal_s: registered; 1 exactly while state==ARMED.
//   - Rises at edge E0+ARM_DELAY.
//   - Falls at the first edge sampling ign=1.
// - Buzzer condition: warn = CarLightsOnSign & OpenDoorSign & ~IgnitionSignalOn.
//   - Edge with warn=1 and buzz_cnt<BUZZ_MAX: PassiveSignal_b<=1, buzz_cnt+1.
//   - Edge with warn=1 and buzz_cnt==BUZZ_MAX: PassiveSignal_b<=0, buzz_cnt holds (no wrap).
//   - Edge with warn=0: PassiveSignal_b<=0, buzz_cnt<=0 (re-arms the warning).
//   - One cycle latency from the input to PassiveSignal_b.
//   - Buzzer is independent of the arming FSM state.
// - Simultaneous events:
//   - ign=1 with any door/light change: ignition wins; s=0, b=0 next edge.
//   - Door reopen at the same edge the countdown would complete: door wins -> WAIT_CLOSE, no arm.
// - Counters saturate at their limits, never wrap; no X on outputs after reset.
// TESTING
// - Assert reset mid-cycle -> both outputs 0 at once; state IDLE; no edge needed.
// - ign 1->0, door 0->1->0, hold door=0 -> PassiveSignal_s rises exactly 10 edges after close edge (ARM_DELAY=10).
// - Reopen door at countdown cycle 5, close again -> s stays 0 until 10 full edges after the second close.
// - ign=1 while ARMED -> s=0 at next edge.
// - ign=1 at countdown cycle 3 -> IDLE, s never rises.
// - lights=1, door=1, ign=0 held 20 cycles (BUZZ_MAX=8) -> b high edges 1..8, low 9..20.
//   - Then drop lights 1 cycle and re-raise -> b high again for 8 edges.
// - Async reset at countdown cycle 7 then release -> no arming.
//   - A full open/close sequence then arms after 10 edges.

Source files
------------

// File: rtl/passive_security_ctrl.sv
// Passive anti-theft controller: arms security after ignition off and a door open/close,
// and sounds a bounded buzzer warning when the lights are left on with the door open.
module passive_security_ctrl #(
    parameter int unsigned ARM_DELAY = 10,
    parameter int unsigned BUZZ_MAX  = 8,
    parameter int unsigned CNT_W     = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic CarLightsOnSign,
    input  logic OpenDoorSign,
    input  logic IgnitionSignalOn,
    output logic PassiveSignal_b,
    output logic PassiveSignal_s
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] WAIT_OPEN  = 3'd1;
    localparam logic [2:0] WAIT_CLOSE = 3'd2;
    localparam logic [2:0] COUNTDOWN  = 3'd3;
    localparam logic [2:0] ARMED      = 3'd4;

    localparam logic [CNT_W-1:0] ARM_LAST = CNT_W'(ARM_DELAY - 1);
    localparam logic [CNT_W-1:0] BUZZ_LIM = CNT_W'(BUZZ_MAX);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] arm_cnt;
    logic [CNT_W-1:0] arm_cnt_nxt;
    logic [CNT_W-1:0] buzz_cnt;
    logic [CNT_W-1:0] buzz_cnt_nxt;
    logic             buzz_nxt;
    logic             warn;

    // State and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            arm_cnt  <= '0;
            buzz_cnt <= '0;
        end else begin
            state    <= state_nxt;
            arm_cnt  <= arm_cnt_nxt;
            buzz_cnt <= buzz_cnt_nxt;
        end
    end

    // Arming next-state: ignition overrides everything
    always_comb begin
        state_nxt   = state;
        arm_cnt_nxt = arm_cnt;
        if (IgnitionSignalOn) begin
            state_nxt   = IDLE;
            arm_cnt_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = WAIT_OPEN;
                end
                WAIT_OPEN: begin
                    if (OpenDoorSign) begin
                        state_nxt = WAIT_CLOSE;
                    end
                end
                WAIT_CLOSE: begin
                    if (!OpenDoorSign) begin
                        state_nxt   = COUNTDOWN;
                        arm_cnt_nxt = '0;
                    end
                end
                COUNTDOWN: begin
                    // A reopen wins over a completing countdown
                    if (OpenDoorSign) begin
                        state_nxt   = WAIT_CLOSE;
                        arm_cnt_nxt = '0;
                    end else if (arm_cnt == ARM_LAST) begin
                        state_nxt = ARMED;
                    end else if (arm_cnt < ARM_LAST) begin
                        arm_cnt_nxt = arm_cnt + CNT_W'(1);
                    end
                end
                ARMED: begin
                    state_nxt = ARMED;
                end
                default: begin
                    state_nxt   = IDLE;
                    arm_cnt_nxt = '0;
                end
            endcase
        end
    end

    // Buzzer: high for at most BUZZ_MAX edges per continuous warning
    always_comb begin
        warn         = CarLightsOnSign & OpenDoorSign & ~IgnitionSignalOn;
        buzz_nxt     = 1'b0;
        buzz_cnt_nxt = '0;
        if (warn) begin
            if (buzz_cnt < BUZZ_LIM) begin
                buzz_nxt     = 1'b1;
                buzz_cnt_nxt = buzz_cnt + CNT_W'(1);
            end else begin
                buzz_cnt_nxt = buzz_cnt;
            end
        end
    end

    // Registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PassiveSignal_s <= 1'b0;
            PassiveSignal_b <= 1'b0;
        end else begin
            PassiveSignal_s <= (state_nxt == ARMED);
            PassiveSignal_b <= buzz_nxt;
        end
    end

endmodule

// File: tb/tb_passive_security_ctrl.sv
// Bench for passive_security_ctrl: directed scenarios plus random traffic checked
// against an event-history model of arming and buzzer behaviour.
module tb_passive_security_ctrl;

    localparam int ARM_DELAY = 10;
    localparam int BUZZ_MAX  = 8;

    logic clk = 1'b0;
    logic reset;
    logic lights;
    logic door;
    logic ign;
    logic buzz;
    logic armed;

    int tests    = 0;
    int failures = 0;

    // Model: history of what the driver has done since the last ignition/reset
    bit m_ign_off;
    bit m_opened;
    int m_closed;
    bit m_armed;
    int m_warn_run;
    bit exp_s;
    bit exp_b;

    passive_security_ctrl #(
        .ARM_DELAY(ARM_DELAY),
        .BUZZ_MAX (BUZZ_MAX),
        .CNT_W    (8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .CarLightsOnSign (lights),
        .OpenDoorSign    (door),
        .IgnitionSignalOn(ign),
        .PassiveSignal_b (buzz),
        .PassiveSignal_s (armed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ign_off  = 1'b0;
        m_opened   = 1'b0;
        m_closed   = 0;
        m_armed    = 1'b0;
        m_warn_run = 0;
        exp_s      = 1'b0;
        exp_b      = 1'b0;
    endtask

    task automatic model_edge(input logic ig, input logic dr, input logic lt);
        bit w;
        if (ig) begin
            m_ign_off = 1'b0;
            m_opened  = 1'b0;
            m_closed  = 0;
            m_armed   = 1'b0;
        end else if (!m_armed) begin
            if (!m_ign_off) begin
                m_ign_off = 1'b1;
            end else if (dr) begin
                m_opened = 1'b1;
                m_closed = 0;
            end else if (m_opened) begin
                m_closed++;
                if (m_closed == ARM_DELAY + 1) m_armed = 1'b1;
            end
        end
        w = lt & dr & ~ig;
        m_warn_run = w ? m_warn_run + 1 : 0;
        exp_b = w && (m_warn_run <= BUZZ_MAX);
        exp_s = m_armed;
    endtask

    // Called in the low clock phase; drives, takes one posedge, checks, returns after negedge
    task automatic step(input logic ig, input logic dr, input logic lt);
        ign    = ig;
        door   = dr;
        lights = lt;
        @(posedge clk);
        model_edge(ig, dr, lt);
        #1;
        check("model_s", armed, exp_s);
        check("model_b", buzz, exp_b);
        @(negedge clk);
    endtask

    // Mid-cycle asynchronous reset pulse with no clock edge inside it
    task automatic reset_pulse();
        #1 reset = 1'b1;
        #1;
        model_reset();
        check("rst_async_s", armed, 1'b0);
        check("rst_async_b", buzz, 1'b0);
        #1 reset = 1'b0;
    endtask

    task automatic open_close();
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bit ig_v;
        bit dr_v;
        bit lt_v;
        reset  = 1'b1;
        ign    = 1'b0;
        door   = 1'b0;
        lights = 1'b0;
        model_reset();
        #1;
        check("reset_s", armed, 1'b0);
        check("reset_b", buzz, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Basic arming: exact latency after the close edge
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        open_close();
        for (int k = 1; k < ARM_DELAY; k++) begin
            step(1'b0, 1'b0, 1'b0);
            check("arm_early", armed, 1'b0);
        end
        step(1'b0, 1'b0, 1'b0);
        check("arm_exact", armed, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        check("armed_door_ignored", armed, 1'b1);

        // Ignition while armed
        step(1'b1, 1'b0, 1'b0);
        check("ign_disarm", armed, 1'b0);

        // Reopen at countdown cycle 5, then full delay after second close
        step(1'b0, 1'b0, 1'b0);
        open_close();
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0);
        open_close();
        for (int k = 1; k < ARM_DELAY; k++) begin
            step(1'b0, 1'b0, 1'b0);
            check("rearm_early", armed, 1'b0);
        end
        step(1'b0, 1'b0, 1'b0);
        check("rearm_exact", armed, 1'b1);

        // Ignition at countdown cycle 3 aborts arming
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        open_close();
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 15; k++) begin
            step(1'b0, 1'b0, 1'b0);
            check("ign_abort", armed, 1'b0);
        end

        // Buzzer window and re-trigger
        step(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            step(1'b0, 1'b1, 1'b1);
            check("buzz_window", buzz, (k <= BUZZ_MAX) ? 1'b1 : 1'b0);
        end
        step(1'b0, 1'b1, 1'b0);
        check("buzz_drop", buzz, 1'b0);
        for (int k = 1; k <= BUZZ_MAX + 1; k++) begin
            step(1'b0, 1'b1, 1'b1);
            check("buzz_retrigger", buzz, (k <= BUZZ_MAX) ? 1'b1 : 1'b0);
        end
        step(1'b1, 1'b1, 1'b1);
        check("buzz_ign", buzz, 1'b0);

        // Async reset at countdown cycle 7 aborts arming
        step(1'b0, 1'b0, 1'b0);
        open_close();
        for (int k = 0; k < 7; k++) step(1'b0, 1'b0, 1'b0);
        reset_pulse();
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b0, 1'b0);
            check("rst_abort", armed, 1'b0);
        end
        open_close();
        for (int k = 1; k < ARM_DELAY; k++) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("post_rst_arm", armed, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        check("pre_rst_s", armed, 1'b1);
        check("pre_rst_b", buzz, 1'b1);
        reset_pulse();

        // Random traffic against the model
        ig_v = 1'b0;
        dr_v = 1'b0;
        lt_v = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 499) == 0) reset_pulse();
            ig_v = (n < 2000) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 7) == 0) dr_v = ~dr_v;
            if ($urandom_range(0, 3) == 0) lt_v = ~lt_v;
            step(ig_v, dr_v, lt_v);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
